// File: rtl/instruction_cache_dm.sv
// Direct-mapped, read-only instruction cache with combinational hit path.
// Misses stall fetch while a line is requested and then filled one word per beat.
module instruction_cache_dm #(
    parameter int FETCH_WIDTH = 2,
    parameter int LINE_WORDS  = 4,
    parameter int NUM_LINES   = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [31:0]                 i_pc,
    input  logic                        i_fetch_req,
    input  logic                        i_flush,
    output logic [32*FETCH_WIDTH-1:0]   o_instr_out,
    output logic [32*FETCH_WIDTH-1:0]   o_pc_out,
    output logic [FETCH_WIDTH-1:0]      o_slot_valid,
    output logic                        o_stall,
    output logic                        o_mem_req_valid,
    input  logic                        i_mem_req_ready,
    output logic [31:0]                 o_mem_req_addr,
    input  logic                        i_mem_resp_valid,
    input  logic [31:0]                 i_mem_resp_data
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [WORD_W-1:0]   r_cnt;
    logic                r_poison;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]    r_fillTag;
    logic [IDX_W-1:0]    r_fillIdx;
    logic [TAG_W-1:0]    r_tagRam  [NUM_LINES];
    logic [31:0]         r_dataRam [NUM_LINES][LINE_WORDS];

    logic [31:0]         w_pcBase;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WORD_W-1:0]   w_word;
    logic                w_hit;
    logic                w_startFill;
    logic                w_beat;
    logic                w_lastBeat;

    assign w_pcBase    = i_pc & 32'hFFFF_FFFC;
    assign w_idx       = i_pc[OFF_W+IDX_W-1:OFF_W];
    assign w_tag       = i_pc[31:OFF_W+IDX_W];
    assign w_word      = i_pc[OFF_W-1:2];

    assign w_hit       = i_fetch_req && (r_state == ST_IDLE) && r_valid[w_idx]
                         && (r_tagRam[w_idx] == w_tag);
    assign w_startFill = i_fetch_req && (r_state == ST_IDLE) && !w_hit;
    assign w_beat      = (r_state == ST_FILL) && i_mem_resp_valid;
    assign w_lastBeat  = w_beat && (r_cnt == WORD_W'(LINE_WORDS - 1));

    assign o_stall        = i_fetch_req && !w_hit;
    assign o_mem_req_addr = {r_fillTag, r_fillIdx, {OFF_W{1'b0}}};

    // Slots past the end of the line are dropped so a bundle never spans two lines.
    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
        logic [WORD_W:0] w_slotWord;
        logic            w_slotOk;

        assign w_slotWord = {1'b0, w_word} + (WORD_W+1)'(g);
        assign w_slotOk   = w_hit && (w_slotWord < (WORD_W+1)'(LINE_WORDS));

        assign o_slot_valid[g]         = w_slotOk;
        assign o_instr_out[32*g +: 32] = w_slotOk ? r_dataRam[w_idx][w_slotWord[WORD_W-1:0]] : 32'h0;
        assign o_pc_out[32*g +: 32]    = w_pcBase + 32'(4 * g);
    end

    always_comb begin
        w_nextState     = r_state;
        o_mem_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startFill) w_nextState = ST_REQ;
            end
            ST_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) w_nextState = ST_FILL;
            end
            ST_FILL: begin
                if (w_lastBeat) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    // A flush while a fill is outstanding poisons that fill so it never becomes valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_poison  <= 1'b0;
            r_fillTag <= '0;
            r_fillIdx <= '0;
        end else if (w_startFill) begin
            r_cnt     <= '0;
            r_poison  <= 1'b0;
            r_fillTag <= w_tag;
            r_fillIdx <= w_idx;
        end else begin
            if (w_beat)                                r_cnt    <= r_cnt + WORD_W'(1);
            if (i_flush && (r_state != ST_IDLE))       r_poison <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                      r_valid            <= '0;
        else if (i_flush)                  r_valid            <= '0;
        else if (w_lastBeat && !r_poison)  r_valid[r_fillIdx] <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_beat)     r_dataRam[r_fillIdx][r_cnt] <= i_mem_resp_data;
        if (w_lastBeat) r_tagRam[r_fillIdx]         <= r_fillTag;
    end

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Directed bench for instruction_cache_dm: the bench plays the backing memory
// and checks hits, misses, fill timing, flush/poison and reset abort.
module tb_instruction_cache_dm;

    localparam int FW = 2;
    localparam int LW = 4;
    localparam int NL = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     pc;
    logic            fetchReq;
    logic            flush;
    logic [32*FW-1:0] instrOut;
    logic [32*FW-1:0] pcOut;
    logic [FW-1:0]   slotValid;
    logic            stall;
    logic            memReqValid;
    logic            memReqReady;
    logic [31:0]     memReqAddr;
    logic            memRespValid;
    logic [31:0]     memRespData;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_cache_dm #(
        .FETCH_WIDTH (FW),
        .LINE_WORDS  (LW),
        .NUM_LINES   (NL)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_pc             (pc),
        .i_fetch_req      (fetchReq),
        .i_flush          (flush),
        .o_instr_out      (instrOut),
        .o_pc_out         (pcOut),
        .o_slot_valid     (slotValid),
        .o_stall          (stall),
        .o_mem_req_valid  (memReqValid),
        .i_mem_req_ready  (memReqReady),
        .o_mem_req_addr   (memReqAddr),
        .i_mem_resp_valid (memRespValid),
        .i_mem_resp_data  (memRespData)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] aPc, input logic aFetch, input logic aFlush,
                                 input logic aReady, input logic aRespValid, input logic [31:0] aRespData);
        pc           = aPc;
        fetchReq     = aFetch;
        flush        = aFlush;
        memReqReady  = aReady;
        memRespValid = aRespValid;
        memRespData  = aRespData;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleOutputs();
        @(negedge clk);
    endtask

    // One complete miss: miss cycle, REQ (optionally backpressured, with junk beats
    // that must be ignored), then LW beats with an optional idle gap and optional flush.
    task automatic fillLine(input string tag, input logic [31:0] missPc, input logic [31:0] busyPc,
                            input logic [31:0] lineAddr, input logic [31:0] dataBase,
                            input int readyLow, input int gapBeat, input int flushBeat);
        applyStimulus(missPc, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput({tag, "_missStall"}, 64'(stall), 64'd1);
        checkOutput({tag, "_missSlots"}, 64'(slotValid), 64'd0);
        checkOutput({tag, "_missNoReq"}, 64'(memReqValid), 64'd0);
        nextCycle();
        for (int k = 0; k < readyLow; k++) begin
            applyStimulus(busyPc, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
            sampleOutputs();
            checkOutput({tag, "_reqHeldValid"}, 64'(memReqValid), 64'd1);
            checkOutput({tag, "_reqHeldAddr"}, 64'(memReqAddr), 64'(lineAddr));
            nextCycle();
        end
        applyStimulus(busyPc, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput({tag, "_reqValid"}, 64'(memReqValid), 64'd1);
        checkOutput({tag, "_reqAddr"}, 64'(memReqAddr), 64'(lineAddr));
        checkOutput({tag, "_reqStall"}, 64'(stall), 64'd1);
        nextCycle();
        for (int b = 0; b < LW; b++) begin
            if (b == gapBeat) begin
                applyStimulus(busyPc, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
                sampleOutputs();
                checkOutput({tag, "_gapStall"}, 64'(stall), 64'd1);
                checkOutput({tag, "_gapNoReq"}, 64'(memReqValid), 64'd0);
                nextCycle();
            end
            applyStimulus(busyPc, 1'b1, (b == flushBeat), 1'b1, 1'b1, dataBase + 32'(b));
            sampleOutputs();
            checkOutput({tag, "_beatStall"}, 64'(stall), 64'd1);
            checkOutput({tag, "_beatNoReq"}, 64'(memReqValid), 64'd0);
            nextCycle();
        end
    endtask

    task automatic checkHit(input string tag, input logic [31:0] aPc, input logic [1:0] expValid,
                            input logic [63:0] expInstr, input logic [63:0] expPc);
        applyStimulus(aPc, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput({tag, "_stall"}, 64'(stall), 64'd0);
        checkOutput({tag, "_slotValid"}, 64'(slotValid), 64'(expValid));
        checkOutput({tag, "_instr"}, instrOut, expInstr);
        checkOutput({tag, "_pcOut"}, pcOut, expPc);
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("rst_reqValid", 64'(memReqValid), 64'd0);
        checkOutput("rst_slotValid", 64'(slotValid), 64'd0);
        checkOutput("rst_instr", instrOut, 64'd0);
        checkOutput("rst_stall", 64'(stall), 64'd1);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();

        // Idle fetch, including the pc_out wrap at the top of the address space.
        applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput("idle_stall", 64'(stall), 64'd0);
        checkOutput("idle_slotValid", 64'(slotValid), 64'd0);
        checkOutput("idle_pcWrap", pcOut, 64'h0000_0000_FFFF_FFFC);
        nextCycle();

        // Cold miss at 0x0, hit exactly six cycles after the miss cycle.
        fillLine("cold", 32'h0, 32'h0, 32'h0, 32'hA0, 0, -1, -1);
        checkHit("coldHit", 32'h0, 2'b11, 64'h0000_00A1_0000_00A0, 64'h0000_0004_0000_0000);
        checkHit("lowBitsIgnored", 32'h3, 2'b11, 64'h0000_00A1_0000_00A0, 64'h0000_0004_0000_0000);
        checkHit("midLine", 32'h8, 2'b11, 64'h0000_00A3_0000_00A2, 64'h0000_000C_0000_0008);
        checkHit("lineEnd", 32'hC, 2'b01, 64'h0000_0000_0000_00A3, 64'h0000_0010_0000_000C);

        // Next line: three ready-low cycles and one idle beat gap delay the hit by four.
        fillLine("bp", 32'h10, 32'h10, 32'h10, 32'hB0, 3, 2, -1);
        checkHit("bpHit", 32'h10, 2'b11, 64'h0000_00B1_0000_00B0, 64'h0000_0014_0000_0010);
        checkHit("bpHigh", 32'h18, 2'b11, 64'h0000_00B3_0000_00B2, 64'h0000_001C_0000_0018);
        checkHit("line0Kept", 32'h4, 2'b11, 64'h0000_00A2_0000_00A1, 64'h0000_0008_0000_0004);

        // Conflict: 0x400 evicts 0x0; pc wanders during the fill without moving the address.
        fillLine("conflict", 32'h400, 32'h10, 32'h400, 32'hC0, 0, -1, -1);
        checkHit("conflictHit", 32'h404, 2'b11, 64'h0000_00C2_0000_00C1, 64'h0000_0408_0000_0404);
        fillLine("refill0", 32'h0, 32'h0, 32'h0, 32'hA0, 0, -1, -1);
        checkHit("refill0Hit", 32'h0, 2'b11, 64'h0000_00A1_0000_00A0, 64'h0000_0004_0000_0000);

        // Flush in IDLE invalidates every line.
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput("flushIdle_stall", 64'(stall), 64'd0);
        nextCycle();
        fillLine("postFlush", 32'h10, 32'h10, 32'h10, 32'hB4, 0, -1, -1);
        checkHit("postFlushHit", 32'h10, 2'b11, 64'h0000_00B5_0000_00B4, 64'h0000_0014_0000_0010);

        // Flush during beat 2 poisons the fill; flush on the final beat does too.
        fillLine("poisonMid", 32'h0, 32'h0, 32'h0, 32'hD0, 0, -1, 2);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput("poisonMid_idleNoReq", 64'(memReqValid), 64'd0);
        checkOutput("poisonMid_idleStall", 64'(stall), 64'd0);
        nextCycle();
        fillLine("poisonLast", 32'h0, 32'h0, 32'h0, 32'hD4, 0, -1, 3);
        fillLine("cleanFill", 32'h0, 32'h0, 32'h0, 32'hE0, 0, -1, -1);
        checkHit("cleanHit", 32'h4, 2'b11, 64'h0000_00E2_0000_00E1, 64'h0000_0008_0000_0004);

        // Reset during beat 1 of a fill at 0x20 aborts it at once.
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF0);
        nextCycle();
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_reqValid", 64'(memReqValid), 64'd0);
        checkOutput("midRst_stall", 64'(stall), 64'd1);
        checkOutput("midRst_slotValid", 64'(slotValid), 64'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        sampleOutputs();
        checkOutput("postRst_reqValid", 64'(memReqValid), 64'd0);
        nextCycle();
        fillLine("postRst", 32'h0, 32'h0, 32'h0, 32'h90, 0, -1, -1);
        checkHit("postRstHit", 32'h8, 2'b11, 64'h0000_0093_0000_0092, 64'h0000_000C_0000_0008);

        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_cache_dm.md
# instruction_cache_dm

Parametrised, direct-mapped, multi-slot instruction cache for a core's fetch stage. It replaces the preloaded flat instruction ROM with a real tag/data array. Line fills come from a backing instruction memory over a valid/ready request channel followed by a beat-per-word response stream. Hits return FETCH_WIDTH consecutive instructions combinationally with their PCs; misses stall fetch until the line is filled.

## Interface
- FETCH_WIDTH, 2: instructions per fetch bundle; power of 2, 1..LINE_WORDS.
- LINE_WORDS, 4: 32-bit words per cache line; power of 2, ≥2.
- NUM_LINES, 64: number of lines; power of 2.
- Derived: OFF_W = log2(LINE_WORDS)+2; IDX_W = log2(NUM_LINES); TAG_W = 32-OFF_W-IDX_W.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pc  in  32  fetch address; bits [1:0] ignored.
- fetch_req  in  1  fetch stage requests a bundle at pc this cycle.
- flush  in  1  invalidate all lines (e.g. self-modifying code or program load).
- instr_out  out  32*FETCH_WIDTH  slot i at bits [32i+31:32i].
- pc_out  out  32*FETCH_WIDTH  slot i = {pc[31:2],2'b00} + 4i, unsigned, modulo 2^32.
- slot_valid  out  FETCH_WIDTH  slot i carries a usable instruction.
- stall  out  1  fetch must hold pc and retry.
- mem_req_valid  out  1  line-fill request pending.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  line-aligned address (low OFF_W bits zero).
- mem_resp_valid  in  1  one fill word present.
- mem_resp_data  in  32  fill word, in ascending address order.

## Operation
- Lookup is combinational: index = pc[OFF_W+IDX_W-1:OFF_W], tag = pc[31:OFF_W+IDX_W], word = pc[OFF_W-1:2].
- hit = fetch_req && state==IDLE && valid[index] && tag_ram[index]==tag.
- On hit, slot i is valid iff word+i < LINE_WORDS. A bundle never crosses a line boundary. Invalid slots drive instr_out = 0.
- On miss or non-IDLE state: slot_valid = 0 and stall = fetch_req. With fetch_req=0, stall = 0 and slot_valid = 0.
- FSM states:
  - IDLE: on fetch_req && !hit, latch {tag, index} and clear the beat counter, then go to REQ.
  - REQ: mem_req_valid=1 and mem_req_addr stays stable until mem_req_ready is sampled high, then go to FILL.
  - FILL: each mem_resp_valid beat writes data[index][cnt] and increments cnt. On beat LINE_WORDS-1, write the tag, set valid[index] (unless the fill was poisoned), and return to IDLE.
- mem_resp_valid outside FILL is ignored. pc changes during REQ/FILL do not alter the latched fill address.
- A fill overwrites the resident line unconditionally (conflict eviction). No write-back is needed; the cache is read-only.
- flush: clears all valid bits at the next edge.
  - Flush in REQ/FILL sets a poison flag. The fill still drains all LINE_WORDS beats, but the line is not marked valid.
  - Flush coincident with the final beat also leaves the line invalid.
- Reset (asynchronous, active-low): state=IDLE, cnt=0, poison=0, all valid bits 0, mem_req_valid=0. Tag/data arrays are not reset.
- Reset asserted mid-fill aborts the fill. The memory side shares the same reset.

## Timing
- Hit: 0-cycle latency, with outputs combinational from pc in the same cycle.
- Miss detected in cycle T: REQ occupies cycle T+1 onward. With mem_req_ready=1 and back-to-back beats, the last beat is in cycle T+1+LINE_WORDS and the hit comes in cycle T+LINE_WORDS+2.
- Each cycle of mem_req_ready=0 and each idle response cycle adds one cycle.
- Outputs in reset: mem_req_valid=0, slot_valid=0, instr_out=0, stall=fetch_req.

## Test plan
- Cold miss, defaults: reset, pc=0x0, fetch_req=1, ready=1, beats 0xA0..0xA3 -> mem_req_addr=0x0 in T+1, stall high T..T+5, at T+6 slot_valid=2'b11, instr_out={0xA1,0xA0}, pc_out={0x4,0x0}.
- Line boundary: after the fill, pc=0xC -> slot_valid=2'b01, slot0=0xA3, pc_out slot1=0x10; pc=0x10 -> miss, mem_req_addr=0x10.
- Backpressure/gaps: mem_req_ready low 3 cycles, one idle beat gap -> addr held stable, hit delayed by exactly 4 cycles, data correct.
- Conflict: fill 0x0, then 0x400 (same index, NUM_LINES=64) -> second fill requested; re-fetch 0x0 misses again.
- Flush: flush after a fill -> next fetch at 0x0 misses. Flush during FILL beat 2 -> all 4 beats consumed, state IDLE, a refetch misses again.
- Reset mid-fill: assert reset in FILL beat 1 -> mem_req_valid=0, state IDLE immediately; after release, pc=0x0 misses and re-requests 0x0.
